spi_fram_responder: RTL and testbench
=====================================

Name: spi_fram_responder

Overview:
- SPI mode-0 target that emulates the FRAM device driven by the CPU's SPI FRAM master.
- Decodes READ/WRITE/WREN/WRDI, holds a byte-addressed internal memory, and returns read data on MISO.
- Used as the on-chip/testbench memory behind the master, so the CPU runs without an external FRAM.
- SPI pins are asynchronous to clk: they are synchronized and edge-detected; clk must be ≥8× SCK frequency.

Parameters:
ADDR_W, 10, memory address width; DEPTH = 2**ADDR_W bytes; the 16-bit SPI address uses its low ADDR_W bits.
SYNC_STAGES, 2, synchronizer flops on spi_sck/spi_cs/spi_mosi (must be ≥2).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
spi_sck  input  1  SPI clock from master, idle low
spi_cs  input  1  chip select, active-low
spi_mosi  input  1  master-out data
spi_miso  output  1  target-out data
wel  output  1  write-enable latch state
busy  output  1  high while synchronized CS is low
wr_blocked  output  1  1-cycle pulse: a data byte was discarded because wel=0

Behaviour:
- Reset values:
  - spi_miso=0, wel=0, busy=0, wr_blocked=0.
  - Synchronizers reset to cs=1, sck=0, mosi=0.
  - State=IDLE.
  - Memory contents are not reset.
- Edges: rise/fall are detected on synchronized SCK; the synchronized MOSI is sampled in the same clk as the detected rise. Bits are MSB first.
- CS rise (synchronized) from any state:
  - Return to IDLE next clk.
  - Discard the partial byte and the bit count.
  - spi_miso<=0.
  - If the command was WRITE, clear wel.
- CS fall: bit counter=0, state=CMD.
- CMD: after 8 rises, decode the opcode:
  - 0x06 WREN: wel<=1, then IGNORE.
  - 0x04 WRDI: wel<=0, then IGNORE.
  - 0x03 READ or 0x02 WRITE: go to ADDR.
  - Any other opcode: IGNORE.
- ADDR: shift 16 bits. After the 16th rise, addr_ptr <= addr[ADDR_W-1:0]; go to RDATA (READ) or WDATA (WRITE).
- RDATA:
  - Load shifter with mem[addr_ptr] on entry.
  - Drive bit7 on spi_miso at the first SCK fall after entry; drive each next bit on each subsequent fall.
  - After the 8th rise of a byte: addr_ptr<=addr_ptr+1 mod DEPTH, reload the shifter, continue streaming.
  - spi_miso must change only on falls, so it is stable at every rise.
- WDATA: on each 8th rise:
  - If wel=1: mem[addr_ptr]<=byte.
  - Else: no write, and wr_blocked pulses for 1 clk.
  - Either way, addr_ptr increments mod DEPTH; stream continues.
- IGNORE: no response; spi_miso=0 until CS rise.
- Outside RDATA, spi_miso is 0.
- Latency: a synchronized edge takes effect SYNC_STAGES+1 clks after the pin edge. Every SCK half-period must be ≥ SYNC_STAGES+2 clks.
- Wrap-around: addr_ptr = DEPTH-1 increments to 0. Address bits above ADDR_W are ignored (aliasing).
- SCK edges while CS is high are ignored.
- A CS rise coinciding with the 8th rise of a byte: the CS rise wins, and the byte is not written.
- Reset mid-transfer: immediate return to reset values. Any memory write not yet committed is lost.

Optional Feature:
FRAM_RDSR_EN:
- Defined: opcode 0x05 RDSR is decoded. Status byte {6'b0, wel, 1'b0} is shifted out on spi_miso, repeating each byte until CS rise.
- Undefined: 0x05 is treated as unknown → IGNORE, spi_miso=0.

Test Plan:
1. WREN; WRITE addr 0x0010 data 0xA5,0x3C; CS high; READ 0x0010 for 2 bytes → MISO 0xA5,0x3C; wel=0 after the WRITE CS rise.
2. After reset (wel=0): WRITE 0x0020 data 0xFF → wr_blocked pulses once. Then WREN; WRITE 0x0020 0x11; READ 0x0020 → 0x11.
3. ADDR_W=10: WREN; WRITE 0x03FF data 0x12,0x34; READ 0x0000 → 0x34; READ 0x07FF → 0x12 (alias).
4. WREN; WRITE 0x0040 0x77; CS rise after 5 data bits; READ 0x0040 → previous content unchanged; state IDLE, busy=0.
5. WREN then WRDI → wel 1 then 0. Opcode 0xAB → no MISO activity; wel unchanged.
6. FRAM_RDSR_EN: WREN; RDSR → 0x02; WRDI; RDSR → 0x00. Without the macro: RDSR → MISO 0x00, no state change.

Source files
------------

// File: rtl/spi_fram_responder.sv
// spi_fram_responder: SPI mode-0 target emulating a byte-addressed FRAM (READ/WRITE/WREN/WRDI).
// Latency: a pin edge acts SYNC_STAGES+1 clk later; MISO changes only on a synchronized SCK fall.
// No backpressure (the SPI master paces all traffic). `define FRAM_RDSR_EN adds the RDSR opcode.
module spi_fram_responder #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic wel,
  output logic busy,
  output logic wr_blocked
);
  localparam int DEPTH = 2 ** ADDR_W;
  // Shifter only keeps bits that can still matter: 7 for an opcode/data byte,
  // ADDR_W-1 for the address (upper address bits fall off the end: aliasing).
  localparam int SH_W  = (ADDR_W > 8) ? ADDR_W : 8;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_IGNORE, S_RDSR} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_prev, r_cs_prev;
  logic [SH_W-2:0]        r_shift;
  logic [3:0]             r_bitcnt;
  logic [ADDR_W-1:0]      r_addr_ptr;
  logic [7:0]             r_tx;
  logic                   r_miso, r_wel, r_is_write, r_wr_blocked;
  logic [7:0]             r_mem [DEPTH];

  logic              w_sck, w_cs, w_mosi;
  logic              w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic              w_last8, w_last16, w_mem_we;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_addr_full, w_ptr_inc;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_sck_fall = ~w_sck & r_sck_prev;
  assign w_cs_rise  = w_cs & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs & r_cs_prev;
  assign w_byte      = {r_shift[6:0], w_mosi};
  assign w_addr_full = {r_shift[ADDR_W-2:0], w_mosi};
  assign w_ptr_inc   = r_addr_ptr + ADDR_W'(1);
  assign w_last8     = (r_bitcnt == 4'd7);
  assign w_last16    = (r_bitcnt == 4'd15);
  // A CS edge in the same clk as the 8th rise wins, so the byte is dropped.
  assign w_mem_we = (r_state == S_WDATA) && w_sck_rise && w_last8 && r_wel &&
                    !w_cs_rise && !w_cs_fall;

  assign spi_miso   = r_miso;
  assign wel        = r_wel;
  assign busy       = ~w_cs;
  assign wr_blocked = r_wr_blocked;

  // Synchronize the asynchronous SPI pins and keep last values for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_cs;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: CS edges take priority over SCK; opcode/address decode on the last rise.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else if (w_cs_fall) begin
      w_state_nxt = S_CMD;
    end else if (w_sck_rise) begin
      case (r_state)
        S_CMD: begin
          if (w_last8) begin
            case (w_byte)
              OP_READ, OP_WRITE: w_state_nxt = S_ADDR;
`ifdef FRAM_RDSR_EN
              OP_RDSR:           w_state_nxt = S_RDSR;
`endif
              default:           w_state_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR:  if (w_last16) w_state_nxt = r_is_write ? S_WDATA : S_RDATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath: bit counting, shifting, WEL, address pointer and MISO shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bitcnt     <= 4'd0;
      r_addr_ptr   <= '0;
      r_tx         <= 8'h00;
      r_miso       <= 1'b0;
      r_wel        <= 1'b0;
      r_is_write   <= 1'b0;
      r_wr_blocked <= 1'b0;
    end else begin
      r_wr_blocked <= 1'b0;
      if (w_cs_rise) begin
        r_bitcnt <= 4'd0;
        r_shift  <= '0;
        r_miso   <= 1'b0;
        if (r_is_write) r_wel <= 1'b0;
      end else if (w_cs_fall) begin
        r_bitcnt   <= 4'd0;
        r_is_write <= 1'b0;
        r_miso     <= 1'b0;
      end else if (w_sck_fall && (r_state == S_RDATA || r_state == S_RDSR)) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end else if (w_sck_rise && r_state != S_IDLE && r_state != S_IGNORE) begin
        r_shift  <= {r_shift[SH_W-3:0], w_mosi};
        r_bitcnt <= r_bitcnt + 4'd1;
        case (r_state)
          S_CMD: begin
            if (w_last8) begin
              r_bitcnt <= 4'd0;
              case (w_byte)
                OP_WREN:  r_wel <= 1'b1;
                OP_WRDI:  r_wel <= 1'b0;
                OP_WRITE: r_is_write <= 1'b1;
`ifdef FRAM_RDSR_EN
                OP_RDSR:  r_tx <= {6'b0, r_wel, 1'b0};
`endif
                default:  r_is_write <= 1'b0;
              endcase
            end
          end
          S_ADDR: begin
            if (w_last16) begin
              r_bitcnt   <= 4'd0;
              r_addr_ptr <= w_addr_full;
              r_tx       <= r_mem[w_addr_full];
            end
          end
          S_RDATA: begin
            if (w_last8) begin
              r_bitcnt   <= 4'd0;
              r_addr_ptr <= w_ptr_inc;
              r_tx       <= r_mem[w_ptr_inc];
            end
          end
          S_WDATA: begin
            if (w_last8) begin
              r_bitcnt   <= 4'd0;
              r_addr_ptr <= w_ptr_inc;
              if (!r_wel) r_wr_blocked <= 1'b1;
            end
          end
`ifdef FRAM_RDSR_EN
          S_RDSR: begin
            if (w_last8) begin
              r_bitcnt <= 4'd0;
              r_tx     <= {6'b0, r_wel, 1'b0};
            end
          end
`endif
          default: r_bitcnt <= 4'd0;
        endcase
      end
    end
  end

  // Memory array: not reset; a write commits only on a completed byte with WEL set.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr_ptr] <= w_byte;
  end

endmodule

// File: tb/tb_spi_fram_responder.sv
// tb_spi_fram_responder: drives the responder as an SPI mode-0 master and checks MISO/WEL/flags.
// Fixed-length transfers only; every wait is a bounded number of clk cycles.
// Vector table, hand-written corner sequences and a randomized phase against a memory model.
module tb_spi_fram_responder;
  logic clk, rst_n, spi_sck, spi_cs, spi_mosi;
  logic spi_miso, wel, busy, wr_blocked;

  spi_fram_responder #(.ADDR_W(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .wel(wel), .busy(busy), .wr_blocked(wr_blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int blk_cnt = 0;
  int miso_hi = 0;
  logic [7:0] wbuf [32];
  logic [7:0] rbuf [32];

  always @(negedge clk) begin
    if (wr_blocked) blk_cnt++;
    if (spi_miso) miso_hi++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half();
    clks(5);
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    spi_cs = 1'b1;
    clks(8);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      half();
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      half();
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = b[i];
      half();
      spi_sck = 1'b1;
      half();
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_cmd(input logic [7:0] op);
    logic [7:0] d;
    cs_begin();
    xfer(op, d);
    cs_end();
  endtask

  task automatic spi_write(input logic [15:0] a, input int n);
    logic [7:0] d;
    cs_begin();
    xfer(8'h02, d);
    xfer(a[15:8], d);
    xfer(a[7:0], d);
    for (int i = 0; i < n; i++) xfer(wbuf[i], d);
    cs_end();
  endtask

  task automatic spi_read(input logic [15:0] a, input int n);
    logic [7:0] d;
    cs_begin();
    xfer(8'h03, d);
    xfer(a[15:8], d);
    xfer(a[7:0], d);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, d);
      rbuf[i] = d;
    end
    cs_end();
  endtask

  typedef struct {
    logic        wren;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [15:0] raddr;
    logic [7:0]  exp_rd;
    int          exp_blk;
  } vec_t;

  initial begin
    vec_t       vt [6];
    logic [7:0] d, exp_sr;
    logic [7:0] mdl [32];
    logic       mwel;
    int         b0, m0, exp_blk, op, n, off;
    logic [5:0] hi;
    logic [15:0] a;

    vt[0] = '{1'b1, 16'h0100, 8'h5A, 16'h0100, 8'h5A, 0};
    vt[1] = '{1'b0, 16'h0100, 8'h99, 16'h0100, 8'h5A, 1};
    vt[2] = '{1'b1, 16'h0500, 8'hC3, 16'h0100, 8'hC3, 0};
    vt[3] = '{1'b1, 16'hFC01, 8'h0F, 16'h0001, 8'h0F, 0};
    vt[4] = '{1'b1, 16'h0002, 8'h80, 16'h0402, 8'h80, 0};
    vt[5] = '{1'b0, 16'h0001, 8'hEE, 16'hF801, 8'h0F, 1};

    rst_n = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    clks(5);
    rst_n = 1'b1;
    clks(4);
    check("rst_miso", spi_miso, 0);
    check("rst_wel", wel, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_blocked", wr_blocked, 0);

    // Blocked write after reset, then a real one.
    b0 = blk_cnt;
    wbuf[0] = 8'hFF;
    spi_write(16'h0020, 1);
    check("t2_blocked_pulses", blk_cnt - b0, 1);
    spi_cmd(8'h06);
    wbuf[0] = 8'h11;
    spi_write(16'h0020, 1);
    spi_read(16'h0020, 1);
    check("t2_read", rbuf[0], 8'h11);

    // Two-byte write/read, WEL cleared by the WRITE.
    spi_cmd(8'h06);
    check("t1_wel_set", wel, 1);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    spi_write(16'h0010, 2);
    check("t1_wel_after_write", wel, 0);
    spi_read(16'h0010, 2);
    check("t1_rd0", rbuf[0], 8'hA5);
    check("t1_rd1", rbuf[1], 8'h3C);

    // Wrap at DEPTH-1 and address aliasing.
    spi_cmd(8'h06);
    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    spi_write(16'h03FF, 2);
    spi_read(16'h0000, 1);
    check("t3_wrap_0000", rbuf[0], 8'h34);
    spi_read(16'h07FF, 1);
    check("t3_alias_07ff", rbuf[0], 8'h12);
    spi_read(16'h03FF, 2);
    check("t3_rdwrap0", rbuf[0], 8'h12);
    check("t3_rdwrap1", rbuf[1], 8'h34);

    // Partial data byte aborted by CS.
    spi_cmd(8'h06);
    wbuf[0] = 8'h66; wbuf[1] = 8'h55;
    spi_write(16'h0040, 2);
    spi_cmd(8'h06);
    cs_begin();
    xfer(8'h02, d); xfer(8'h00, d); xfer(8'h40, d);
    send_bits(8'h77, 5);
    check("t4_busy_mid", busy, 1);
    cs_end();
    check("t4_busy_after", busy, 0);
    check("t4_miso_after", spi_miso, 0);
    check("t4_wel_after", wel, 0);
    spi_read(16'h0040, 1);
    check("t4_unchanged", rbuf[0], 8'h66);

    // CS rise in the same clk as the 8th data rise: byte dropped.
    spi_cmd(8'h06);
    cs_begin();
    xfer(8'h02, d); xfer(8'h00, d); xfer(8'h41, d);
    send_bits(8'h99, 7);
    spi_mosi = 1'b1;
    half();
    spi_sck = 1'b1;
    spi_cs = 1'b1;
    half();
    spi_sck = 1'b0;
    clks(8);
    check("cs_coincide_wel", wel, 0);
    spi_read(16'h0041, 1);
    check("cs_coincide_unwritten", rbuf[0], 8'h55);

    // WREN/WRDI and an unknown opcode.
    spi_cmd(8'h06);
    check("t5_wren", wel, 1);
    spi_cmd(8'h04);
    check("t5_wrdi", wel, 0);
    spi_cmd(8'h06);
    m0 = miso_hi;
    cs_begin();
    xfer(8'hAB, d); xfer(8'hFF, d); xfer(8'hFF, d);
    cs_end();
    check("t5_unknown_miso_quiet", miso_hi - m0, 0);
    check("t5_unknown_wel", wel, 1);

    // RDSR (status only when the feature is built in).
`ifdef FRAM_RDSR_EN
    exp_sr = 8'h02;
`else
    exp_sr = 8'h00;
`endif
    cs_begin();
    xfer(8'h05, d); xfer(8'h00, d);
    check("t6_rdsr_wel1_b0", d, exp_sr);
    xfer(8'h00, d);
    check("t6_rdsr_wel1_b1", d, exp_sr);
    cs_end();
    check("t6_wel_kept", wel, 1);
    spi_cmd(8'h04);
    cs_begin();
    xfer(8'h05, d); xfer(8'h00, d);
    cs_end();
    check("t6_rdsr_wel0", d, 8'h00);

    // Reset in the middle of a read stream.
    spi_cmd(8'h06);
    cs_begin();
    xfer(8'h03, d); xfer(8'h00, d); xfer(8'h10, d);
    clks(4);
    check("rstmid_bit7_driven", spi_miso, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_miso", spi_miso, 0);
    check("rstmid_wel", wel, 0);
    check("rstmid_busy", busy, 0);
    spi_cs = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(4);

    // Vector table: optional WREN, single-byte write, single-byte read.
    for (int i = 0; i < 6; i++) begin
      b0 = blk_cnt;
      if (vt[i].wren) spi_cmd(8'h06);
      wbuf[0] = vt[i].wdata;
      spi_write(vt[i].waddr, 1);
      spi_read(vt[i].raddr, 1);
      check($sformatf("vec%0d_rd", i), rbuf[0], vt[i].exp_rd);
      check($sformatf("vec%0d_wel", i), wel, 0);
      check($sformatf("vec%0d_blk", i), blk_cnt - b0, vt[i].exp_blk);
    end

    // Randomized traffic over locations 0..31 (random alias bits) against a model.
    spi_cmd(8'h06);
    for (int i = 0; i < 32; i++) begin
      wbuf[i] = 8'($urandom);
      mdl[i] = wbuf[i];
    end
    spi_write(16'h0000, 32);
    mwel = 1'b0;
    exp_blk = blk_cnt;
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      off = $urandom_range(0, 32 - n);
      hi = 6'($urandom_range(0, 63));
      a = {hi, 5'b0, 5'(off)};
      case (op)
        0: begin spi_cmd(8'h06); mwel = 1'b1; end
        1: begin spi_cmd(8'h04); mwel = 1'b0; end
        2: begin
          for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
          spi_write(a, n);
          for (int k = 0; k < n; k++) begin
            if (mwel) mdl[off + k] = wbuf[k];
          end
          if (!mwel) exp_blk += n;
          mwel = 1'b0;
        end
        default: begin
          spi_read(a, n);
          for (int k = 0; k < n; k++)
            check($sformatf("rnd%0d_rd%0d", t, k), rbuf[k], mdl[off + k]);
        end
      endcase
      check($sformatf("rnd%0d_wel", t), wel, mwel);
      check($sformatf("rnd%0d_blk", t), blk_cnt, exp_blk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
